// File: rtl/fifo_write_arbiter.sv
// Round-robin write arbiter: one requester at a time owns the shared FIFO write
// port for a burst of up to MAX_BURST words, ended early by req_last.
module fifo_write_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DW-1:0]      req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    fifo_full,
  output logic                    fifo_push,
  output logic [DW-1:0]           fifo_data,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic [15:0]             push_count
);
  localparam int GW = $clog2(NREQ);

  typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [3:0]    burst_cnt_q, burst_cnt_d;
  logic [15:0]   push_count_q, push_count_d;
  logic [GW-1:0] pick_s;
  logic [GW-1:0] scan_idx_s;
  logic          any_valid_s;

  function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] v);
    if (v == GW'(NREQ - 1)) begin
      return '0;
    end else begin
      return v + GW'(1);
    end
  endfunction

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    pick_s      = rr_ptr_q;
    any_valid_s = 1'b0;
    scan_idx_s  = rr_ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!any_valid_s && req_valid[scan_idx_s]) begin
        any_valid_s = 1'b1;
        pick_s      = scan_idx_s;
      end else begin
        any_valid_s = any_valid_s;
      end
      scan_idx_s = wrap_inc(scan_idx_s);
    end
  end

  // Next-state and handshake logic; no word is accepted in IDLE.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    burst_cnt_d  = burst_cnt_q;
    push_count_d = push_count_q;
    req_ready    = '0;
    fifo_push    = 1'b0;
    fifo_data    = req_data[int'(grant_q)*DW +: DW];
    case (state_q)
      IDLE: begin
        if (any_valid_s) begin
          grant_d     = pick_s;
          burst_cnt_d = 4'd0;
          state_d     = BURST;
        end else begin
          state_d = IDLE;
        end
      end
      BURST: begin
        req_ready[grant_q] = !fifo_full;
        fifo_push          = req_valid[grant_q] & !fifo_full;
        if (fifo_push) begin
          burst_cnt_d  = burst_cnt_q + 4'd1;
          push_count_d = push_count_q + 16'd1;
          // A burst closes on its last word or when the word budget is used up.
          if (req_last[grant_q] || ((burst_cnt_q + 4'd1) == 4'(MAX_BURST))) begin
            state_d  = IDLE;
            rr_ptr_d = wrap_inc(grant_q);
          end else begin
            state_d = BURST;
          end
        end else begin
          state_d = BURST;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      burst_cnt_q  <= 4'd0;
      push_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      burst_cnt_q  <= burst_cnt_d;
      push_count_q <= push_count_d;
    end
  end

  assign grant_id   = grant_q;
  assign busy       = (state_q == BURST);
  assign push_count = push_count_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: per-requester word streams, expected
// FIFO word order queued up front and popped on every observed push.
module tb_fifo_write_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              fifo_full;
  logic              fifo_push;
  logic [DW-1:0]     fifo_data;
  logic [1:0]        grant_id;
  logic              busy;
  logic [15:0]       push_count;

  logic        w_rst;
  logic [1:0]  w_valid, w_last, w_ready;
  logic [15:0] w_data;
  logic        w_full, w_push, w_busy;
  logic [7:0]  w_fdata;
  logic [0:0]  w_grant;
  logic [15:0] w_pcount;

  fifo_write_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(4)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_push(fifo_push), .fifo_data(fifo_data), .grant_id(grant_id),
    .busy(busy), .push_count(push_count)
  );

  // Second instance with long bursts, used only to wrap push_count quickly.
  fifo_write_arbiter #(.NREQ(2), .DW(8), .MAX_BURST(15)) u_wrap (
    .clk(clk), .rst(w_rst), .req_valid(w_valid), .req_data(w_data),
    .req_last(w_last), .req_ready(w_ready), .fifo_full(w_full),
    .fifo_push(w_push), .fifo_data(w_fdata), .grant_id(w_grant),
    .busy(w_busy), .push_count(w_pcount)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int seq_n    [NREQ];
  int len_n    [NREQ];
  bit last_end [NREQ];
  bit last_all [NREQ];
  logic [DW-1:0]   exp_q[$];
  int              cyc;
  logic [31:0]     push_hist, busy_hist;
  logic            obs_push, obs_busy;
  logic [NREQ-1:0] obs_ready;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]         = (seq_n[i] < len_n[i]);
      req_data[i*DW +: DW] = {4'(i), 12'(seq_n[i])};
      req_last[i]          = last_all[i] || (last_end[i] && (seq_n[i] == len_n[i] - 1));
    end
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NREQ; i++) begin
      seq_n[i] = 0; len_n[i] = 0; last_end[i] = 1'b0; last_all[i] = 1'b0;
    end
  endtask

  task automatic expect_word(input int req, input int w);
    exp_q.push_back({4'(req), 12'(w)});
  endtask

  task automatic observe();
    logic [DW-1:0] e;
    obs_push  = fifo_push;
    obs_busy  = busy;
    obs_ready = req_ready;
    if (cyc < 32) begin
      push_hist[cyc[4:0]] = fifo_push;
      busy_hist[cyc[4:0]] = busy;
    end
    check_val("push_implies_not_full", {31'd0, fifo_push & fifo_full}, 32'd0);
    check_val("ready_at_most_one", ($countones(req_ready) <= 1) ? 32'd1 : 32'd0, 32'd1);
    check_val("push_eq_handshake", {31'd0, fifo_push}, {31'd0, |(req_valid & req_ready)});
    if (!busy) begin
      check_val("idle_no_ready", {28'd0, req_ready}, 32'd0);
    end
    if (fifo_push) begin
      check_val("sb_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_val("sb_data", {16'd0, fifo_data}, {16'd0, e});
        check_val("sb_grant", {30'd0, grant_id}, {28'd0, e[15:12]});
      end
    end
  endtask

  task automatic step();
    logic [NREQ-1:0] acc;
    @(negedge clk);
    observe();
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) seq_n[i]++;
    end
    cyc++;
    drive_inputs();
  endtask

  task automatic run_until_empty(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    check_val("sb_drained", exp_q.size(), 32'd0);
  endtask

  task automatic apply_reset();
    rst       = 1'b0;
    fifo_full = 1'b0;
    clear_sources();
    for (int i = 0; i < NREQ; i++) len_n[i] = 1;
    drive_inputs();
    exp_q.delete();
    @(negedge clk);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_grant", {30'd0, grant_id}, 32'd0);
    check_val("rst_push_count", {16'd0, push_count}, 32'd0);
    check_val("rst_ready", {28'd0, req_ready}, 32'd0);
    check_val("rst_push", {31'd0, fifo_push}, 32'd0);
    clear_sources();
    drive_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc       = 1;
    push_hist = 32'd0;
    busy_hist = 32'd0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushes;
    int cycles;
    rst = 1'b0; w_rst = 1'b0; fifo_full = 1'b0;
    w_valid = 2'b00; w_last = 2'b00; w_data = 16'h1234; w_full = 1'b0;
    cyc = 0; push_hist = 32'd0; busy_hist = 32'd0;
    clear_sources();
    drive_inputs();

    // Two 3-word bursts with last: exact cycle timing and turnaround.
    apply_reset();
    len_n[0] = 3; last_end[0] = 1'b1;
    len_n[2] = 3; last_end[2] = 1'b1;
    drive_inputs();
    for (int w = 0; w < 3; w++) expect_word(0, w);
    for (int w = 0; w < 3; w++) expect_word(2, w);
    repeat (9) step();
    check_val("t1_push_cycles", push_hist, 32'h0000_01DC);
    check_val("t1_busy_cycles", busy_hist, 32'h0000_01DC);
    check_val("t1_push_count", {16'd0, push_count}, 32'd6);
    check_val("t1_sb_drained", exp_q.size(), 32'd0);

    // Long stream without last is cut at MAX_BURST and shares with requester 3.
    apply_reset();
    len_n[1] = 10;
    len_n[3] = 2; last_end[3] = 1'b1;
    drive_inputs();
    for (int w = 0; w < 4; w++) expect_word(1, w);
    for (int w = 0; w < 2; w++) expect_word(3, w);
    for (int w = 4; w < 10; w++) expect_word(1, w);
    run_until_empty(60);
    repeat (3) step();
    check_val("t2_wait_busy", {31'd0, obs_busy}, 32'd1);
    check_val("t2_wait_grant", {30'd0, grant_id}, 32'd1);
    check_val("t2_push_count", {16'd0, push_count}, 32'd12);

    // FIFO full for 5 cycles mid-burst freezes the burst.
    apply_reset();
    len_n[0] = 4;
    drive_inputs();
    for (int w = 0; w < 4; w++) expect_word(0, w);
    repeat (3) step();
    fifo_full = 1'b1;
    repeat (5) begin
      step();
      check_val("t3_full_ready", {28'd0, obs_ready}, 32'd0);
      check_val("t3_full_push", {31'd0, obs_push}, 32'd0);
      check_val("t3_full_busy", {31'd0, obs_busy}, 32'd1);
      check_val("t3_full_grant", {30'd0, grant_id}, 32'd0);
    end
    fifo_full = 1'b0;
    step();
    check_val("t3_resume_push", {31'd0, obs_push}, 32'd1);
    step();
    step();
    check_val("t3_burst_closed", {31'd0, obs_busy}, 32'd0);
    check_val("t3_sb_drained", exp_q.size(), 32'd0);

    // All requesters always valid with last on every word: strict rotation.
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      len_n[i] = 100; last_all[i] = 1'b1;
    end
    drive_inputs();
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < NREQ; i++) expect_word(i, w);
    end
    expect_word(0, 2);
    run_until_empty(40);

    // Reset during the second word of a burst, then arbitration restarts at 0.
    apply_reset();
    len_n[1] = 1; last_end[1] = 1'b1;
    len_n[2] = 3; last_end[2] = 1'b1;
    drive_inputs();
    expect_word(1, 0);
    expect_word(2, 0);
    run_until_empty(20);
    check_val("t5_push_before_rst", {31'd0, fifo_push}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_val("t5_rst_push", {31'd0, fifo_push}, 32'd0);
    check_val("t5_rst_busy", {31'd0, busy}, 32'd0);
    check_val("t5_rst_count", {16'd0, push_count}, 32'd0);
    check_val("t5_rst_ready", {28'd0, req_ready}, 32'd0);
    clear_sources();
    len_n[1] = 1; last_end[1] = 1'b1;
    len_n[3] = 1; last_end[3] = 1'b1;
    drive_inputs();
    expect_word(1, 0);
    expect_word(3, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc = 1;
    run_until_empty(20);

    // push_count wraps through 0xFFFF to 0x0001.
    @(negedge clk);
    w_rst   = 1'b1;
    w_valid = 2'b11;
    pushes  = 0;
    cycles  = 0;
    while (pushes < 65535 && cycles < 80000) begin
      @(negedge clk);
      if (w_push) pushes++;
      cycles++;
    end
    @(posedge clk);
    #1;
    check_val("wrap_ffff", {16'd0, w_pcount}, 32'h0000_FFFF);
    while (pushes < 65537 && cycles < 80000) begin
      @(negedge clk);
      if (w_push) pushes++;
      cycles++;
    end
    @(posedge clk);
    #1;
    check_val("wrap_budget", {31'd0, cycles < 80000}, 32'd1);
    check_val("wrap_0001", {16'd0, w_pcount}, 32'h0000_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
